// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial MSB-first pattern transmitter with repeats and idle gaps.
// Define SEQ_TX_PARITY_EN to append an even-parity bit after each pattern copy.
module seq_pattern_tx #(
  parameter int PAT_W   = 8,
  parameter int LEN_W   = 4,
  parameter int GAP_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [3:0]       reps,
  input  logic             abort,
  output logic             C,
  output logic             c_valid,
  output logic             busy,
  output logic             done,
  output logic             err
);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [LEN_W-1:0] PAT_L = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] L1 = LEN_W'(1);
  localparam logic [GW-1:0] GAP_L = GW'(GAP_CYC - 1);
  typedef enum logic [2:0] {
    IDLE,
    SEND,
`ifdef SEQ_TX_PARITY_EN
    PAR,
`endif
    GAP,
    DONE
  } state_t;
  state_t state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, len_c;
  logic [3:0] reps_q, reps_d;
  logic [GW-1:0] gap_q, gap_d;
  logic c_q, c_d, cv_q, cv_d, busy_q, busy_d, done_q, done_d, err_q, err_d, fin;
`ifdef SEQ_TX_PARITY_EN
  logic par_q, par_d;
`endif
  function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
    return |(p & (PAT_W'(1) << i));
  endfunction
  // Outputs are registered from next-state values so the first bit shows right after the start edge.
  always_comb begin
    state_d = state_q;
    pat_d = pat_q;
    len_d = len_q;
    reps_d = reps_q;
    idx_d = idx_q;
    gap_d = gap_q;
    c_d = 1'b0;
    cv_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    fin = 1'b0;
    len_c = (len > PAT_L) ? PAT_L : len;
`ifdef SEQ_TX_PARITY_EN
    par_d = par_q;
`endif
    if (state_q == IDLE) begin
      if (start && !abort && len == '0) begin
        err_d = 1'b1;
      end else if (start && !abort) begin
        pat_d = pattern;
        len_d = len_c;
        reps_d = (reps == 4'd0) ? 4'd1 : reps;
        idx_d = len_c - L1;
        c_d = bit_at(pattern, idx_d);
        cv_d = 1'b1;
        state_d = SEND;
`ifdef SEQ_TX_PARITY_EN
        par_d = c_d;
`endif
      end
    end else if (state_q == SEND) begin
      if (idx_q != '0) begin
        idx_d = idx_q - L1;
        c_d = bit_at(pat_q, idx_d);
        cv_d = 1'b1;
`ifdef SEQ_TX_PARITY_EN
        par_d = par_q ^ c_d;
`endif
      end else begin
`ifdef SEQ_TX_PARITY_EN
        state_d = PAR;
        c_d = par_q;
        cv_d = 1'b1;
`else
        fin = 1'b1;
`endif
      end
`ifdef SEQ_TX_PARITY_EN
    end else if (state_q == PAR) begin
      fin = 1'b1;
`endif
    end else if (state_q == GAP) begin
      if (gap_q != '0) begin
        gap_d = gap_q - GW'(1);
      end else begin
        state_d = SEND;
        idx_d = len_q - L1;
        c_d = bit_at(pat_q, idx_d);
        cv_d = 1'b1;
`ifdef SEQ_TX_PARITY_EN
        par_d = c_d;
`endif
      end
    end else begin
      state_d = IDLE;
    end
    if (fin) begin
      state_d = (reps_q > 4'd1) ? GAP : DONE;
      reps_d = (reps_q > 4'd1) ? reps_q - 4'd1 : reps_q;
      gap_d = GAP_L;
      done_d = !(reps_q > 4'd1);
    end
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      c_d = 1'b0;
      cv_d = 1'b0;
      done_d = 1'b0;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pat_q <= '0;
      len_q <= '0;
      reps_q <= '0;
      idx_q <= '0;
      gap_q <= '0;
      c_q <= 1'b0;
      cv_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
      par_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pat_q <= pat_d;
      len_q <= len_d;
      reps_q <= reps_d;
      idx_q <= idx_d;
      gap_q <= gap_d;
      c_q <= c_d;
      cv_q <= cv_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
`ifdef SEQ_TX_PARITY_EN
      par_q <= par_d;
`endif
    end
  end
  assign C = c_q;
  assign c_valid = cv_q;
  assign busy = busy_q;
  assign done = done_q;
  assign err = err_q;
endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: scoreboard bench; stimulus queues timed expected events, a monitor pops and compares them.
module tb_seq_pattern_tx;
  localparam int GAP = 2;
`ifdef SEQ_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  typedef struct {
    int   kind;
    logic val;
    int   cyc;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n, start, abort;
  logic [7:0] pattern;
  logic [3:0] len, reps;
  logic C, c_valid, busy, done, err;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int t0;
  bit mon_en = 1'b0;
  ev_t q[$];
  ev_t me;
  int mk;
  logic mv;
  seq_pattern_tx #(.PAT_W(8), .LEN_W(4), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .len(len), .reps(reps),
    .abort(abort), .C(C), .c_valid(c_valid), .busy(busy), .done(done), .err(err)
  );
  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // Expected event kinds: 0 = bit on C, 1 = done pulse, 2 = err pulse.
  task automatic exp_tx(input logic [7:0] p, input int l, input int r, input int ts);
    int lc = (l > 8) ? 8 : l;
    int rc = (r == 0) ? 1 : r;
    int t = ts;
    for (int k = 0; k < rc; k++) begin
      for (int b = lc - 1; b >= 0; b--) begin
        t++;
        q.push_back('{0, p[b], t});
      end
`ifdef SEQ_TX_PARITY_EN
      t++;
      q.push_back('{0, ^(p & 8'((1 << lc) - 1)), t});
`endif
      if (k < rc - 1) t += GAP;
    end
    t++;
    q.push_back('{1, 1'b1, t});
  endtask
  task automatic kick(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r, input logic ab);
    pattern = p;
    len = l;
    reps = r;
    abort = ab;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
  endtask
  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  always @(negedge clk) begin
    if (mon_en) begin
      n_cmp++;
      if (!c_valid && C !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_c: C=%0b with c_valid=0, required 0 (cycle %0d)", C, cyc);
      end
      if (c_valid || done || err) begin
        mk = c_valid ? 0 : (done ? 1 : 2);
        mv = c_valid ? C : 1'b1;
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_out: kind=%0d val=%0b at cycle %0d, required no output", mk, mv, cyc);
        end else begin
          me = q.pop_front();
          if (me.kind != mk || me.val !== mv || me.cyc != cyc) begin
            n_bad++;
            $display("FAIL sb_event: got kind=%0d val=%0b cycle=%0d, required kind=%0d val=%0b cycle=%0d",
                     mk, mv, cyc, me.kind, me.val, me.cyc);
          end
        end
      end
    end
  end
  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    pattern = '0;
    len = '0;
    reps = '0;
    repeat (3) @(negedge clk);
    check("rst_C", C, 0);
    check("rst_c_valid", c_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    t0 = cyc;
    exp_tx(8'hB2, 8, 1, t0);
    kick(8'hB2, 4'd8, 4'd1, 1'b0);
    wait_to(t0 + 9 + PB);
    check("b2_busy_in_done", busy, 1);
    wait_to(t0 + 10 + PB);
    check("b2_busy_after", busy, 0);
    t0 = cyc;
    exp_tx(8'h05, 3, 2, t0);
    kick(8'h05, 4'd3, 4'd2, 1'b0);
    pattern = 8'hFF;
    len = 4'd7;
    reps = 4'd9;
    start = 1'b1;
    wait_to(t0 + 8);
    start = 1'b0;
    wait_to(t0 + 10 + 2 * PB);
    check("rep_busy_after", busy, 0);
    t0 = cyc;
    q.push_back('{2, 1'b1, t0 + 1});
    kick(8'hFF, 4'd0, 4'd1, 1'b0);
    check("len0_busy", busy, 0);
    @(negedge clk);
    check("len0_busy_next", busy, 0);
    kick(8'hFF, 4'd4, 4'd1, 1'b1);
    check("abort_start_busy", busy, 0);
    @(negedge clk);
    check("abort_start_busy_next", busy, 0);
    t0 = cyc;
    exp_tx(8'hA5, 5, 0, t0);
    kick(8'hA5, 4'd5, 4'd0, 1'b0);
    wait_to(t0 + 8 + PB);
    t0 = cyc;
    exp_tx(8'h3C, 12, 1, t0);
    kick(8'h3C, 4'd12, 4'd1, 1'b0);
    wait_to(t0 + 11 + PB);
    t0 = cyc;
    for (int b = 7; b >= 4; b--) q.push_back('{0, b >= 6, t0 + 8 - b});
    kick(8'hC3, 4'd8, 4'd1, 1'b0);
    wait_to(t0 + 4);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_c_valid", c_valid, 0);
    check("abort_busy", busy, 0);
    wait_to(t0 + 14);
    t0 = cyc;
    q.push_back('{0, 1'b1, t0 + 1});
    q.push_back('{0, 1'b0, t0 + 2});
    q.push_back('{0, 1'b1, t0 + 3});
    if (PB == 1) q.push_back('{0, 1'b0, t0 + 4});
    kick(8'h05, 4'd3, 4'd2, 1'b0);
    wait_to(t0 + 4 + PB);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("gaprst_C", C, 0);
    check("gaprst_c_valid", c_valid, 0);
    check("gaprst_busy", busy, 0);
    check("gaprst_done", done, 0);
    check("gaprst_err", err, 0);
    t0 = cyc;
    exp_tx(8'h0B, 4, 1, t0);
    kick(8'h0B, 4'd4, 4'd1, 1'b0);
    wait_to(t0 + 7 + PB);
    check("post_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    check("sb_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
